keypad_scan_onehot: RTL and testbench

//   Scans a 4x4 active-low matrix keypad and debounces it. Drives the 16-bit one-hot key code

---
 rtl/keypad_pkg.sv | 28 ++
 rtl/keypad_debounce.sv | 96 +++++++++
 rtl/keypad_scan_onehot.sv | 102 ++++++++++
 tb/tb_keypad_scan_onehot.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: matrix geometry, per-frame scan result
// encoding and the index to one-hot key code helper.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KEYS = ROWS * COLS;

  typedef enum logic [1:0] {
    RES_NONE    = 2'd0,
    RES_KEY     = 2'd1,
    RES_INVALID = 2'd2
  } res_kind_e;

  // idx is kept at zero for NONE/INVALID so whole-struct equality compares results
  typedef struct packed {
    res_kind_e  kind;
    logic [3:0] idx;
  } frame_res_t;

  function automatic logic [KEYS-1:0] idx_to_onehot(input logic [3:0] idx);
    logic [KEYS-1:0] code;
    code      = '0;
    code[idx] = 1'b1;
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce: turns a stream of per-frame scan results into a stable
// one-hot code with press pulses. Auto-repeat is built only with KEYPAD_REPEAT_EN.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 20,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frame_stb,
  input  frame_res_t      frame_res,
  output logic [KEYS-1:0] onehot,
  output logic            key_press,
  output logic            key_valid
);

  localparam int MW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(DEBOUNCE_FRAMES);

  // Reset as INVALID so the first real frame always starts a fresh run
  localparam frame_res_t RES_RST = '{kind: RES_INVALID, idx: 4'd0};

  frame_res_t      prev_res;
  logic [MW-1:0]   match_cnt, match_nxt;
  logic [KEYS-1:0] code_nxt;
  logic            changed, press_nxt, rep_fire;

  always_comb begin
    match_nxt = match_cnt;
    code_nxt  = onehot;
    if (frame_res.kind == RES_INVALID)
      match_nxt = '0;
    else if (frame_res == prev_res)
      match_nxt = (match_cnt == MATCH_MAX) ? MATCH_MAX : match_cnt + MW'(1);
    else
      match_nxt = MW'(1);
    if (match_nxt == MATCH_MAX)
      code_nxt = (frame_res.kind == RES_KEY) ? idx_to_onehot(frame_res.idx) : '0;
    changed   = (code_nxt != onehot);
    press_nxt = changed && (onehot == '0);
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_WRAP  = RW'(REPEAT_DELAY + REPEAT_PERIOD);

  logic [RW-1:0] rep_cnt, rep_nxt;

  // Counts frames on an unchanged key; folds back to REP_FIRST so it stays bounded
  always_comb begin
    rep_fire = 1'b0;
    rep_nxt  = rep_cnt;
    if (changed || onehot == '0) begin
      rep_nxt = '0;
    end else begin
      rep_nxt = rep_cnt + RW'(1);
      if (rep_nxt == REP_FIRST) begin
        rep_fire = 1'b1;
      end else if (rep_nxt == REP_WRAP) begin
        rep_fire = 1'b1;
        rep_nxt  = REP_FIRST;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)         rep_cnt <= '0;
    else if (frame_stb) rep_cnt <= rep_nxt;
`else
  logic unused_rep;
  assign unused_rep = REPEAT_DELAY[0] ^ REPEAT_PERIOD[0];
  assign rep_fire   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_res  <= RES_RST;
      match_cnt <= '0;
      onehot    <= '0;
      key_valid <= 1'b0;
      key_press <= 1'b0;
    end else if (frame_stb) begin
      prev_res  <= frame_res;
      match_cnt <= match_nxt;
      onehot    <= code_nxt;
      key_valid <= (code_nxt != '0);
      key_press <= press_nxt | rep_fire;
    end else begin
      key_press <= 1'b0;
    end
  end

endmodule

// File: rtl/keypad_scan_onehot.sv
// 4x4 active-low keypad scanner: row drive, column synchronizer and per-frame
// hit accumulation feeding keypad_debounce. Optional auto-repeat: KEYPAD_REPEAT_EN.
module keypad_scan_onehot
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50_000,
  parameter int DEBOUNCE_FRAMES = 20,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [COLS-1:0] col_in,
  output logic [ROWS-1:0] row_out,
  output logic [KEYS-1:0] onehot,
  output logic            key_press,
  output logic            key_valid
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0]   div;
  logic [1:0]      row;
  logic [COLS-1:0] col_s1, col_s2, low;
  logic [1:0]      col_idx;
  logic [2:0]      n_low;
  logic            sample, frame_stb;
  logic            acc_hit, acc_inv, nxt_hit, nxt_inv;
  logic [3:0]      acc_idx, nxt_idx;
  frame_res_t      frame_res;

  assign row_out = ~(ROWS'(1) << row);
  assign low     = ~col_s2;
  assign sample  = (div == DIV_LAST);

  always_comb begin
    col_idx = '0;
    n_low   = '0;
    for (int c = 0; c < COLS; c++)
      if (low[c]) begin
        col_idx = 2'(c);
        n_low   = n_low + 3'd1;
      end
  end

  // Fold this row's sample into the frame; row 3's sample completes the result
  always_comb begin
    nxt_inv   = acc_inv | (n_low > 3'd1) | (n_low == 3'd1 && acc_hit);
    nxt_hit   = acc_hit | (n_low == 3'd1);
    nxt_idx   = (n_low == 3'd1) ? {row, col_idx} : acc_idx;
    frame_stb = sample && (row == 2'(ROWS - 1));
    frame_res = '{kind: RES_NONE, idx: 4'd0};
    if (nxt_inv)      frame_res.kind = RES_INVALID;
    else if (nxt_hit) frame_res = '{kind: RES_KEY, idx: nxt_idx};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div     <= '0;
      row     <= '0;
      col_s1  <= '1;
      col_s2  <= '1;
      acc_hit <= 1'b0;
      acc_inv <= 1'b0;
      acc_idx <= '0;
    end else begin
      col_s1 <= col_in;
      col_s2 <= col_s1;
      if (sample) begin
        div <= '0;
        row <= row + 2'd1;
        if (frame_stb) begin
          acc_hit <= 1'b0;
          acc_inv <= 1'b0;
          acc_idx <= '0;
        end else begin
          acc_hit <= nxt_hit;
          acc_inv <= nxt_inv;
          acc_idx <= nxt_idx;
        end
      end else begin
        div <= div + DW'(1);
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_deb (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_stb (frame_stb),
    .frame_res (frame_res),
    .onehot    (onehot),
    .key_press (key_press),
    .key_valid (key_valid)
  );

endmodule

// File: tb/tb_keypad_scan_onehot.sv
// Bench for keypad_scan_onehot: a keypad matrix model, a directed frame table,
// randomized frames against a frame-level reference model, and reset sequences.
module tb_keypad_scan_onehot;

  localparam int DF = 3;
  localparam int RD = 4;
  localparam int RP = 2;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col_in, row_out;
  logic [15:0] onehot;
  logic        key_press, key_valid;
  logic [15:0] keys;

  int n_chk  = 0;
  int n_fail = 0;
  int frame_no = 0;

  always #5 clk = ~clk;

  keypad_scan_onehot #(
    .SCAN_DIV(4), .DEBOUNCE_FRAMES(DF), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .col_in(col_in), .row_out(row_out),
    .onehot(onehot), .key_press(key_press), .key_valid(key_valid)
  );

  // Matrix: a held key pulls its column low whenever its row is driven low
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (frame %0d): got %h, expected %h", name, frame_no, act, exp);
    end
  endtask

  // Reference model: classify each frame by how many keys are down, debounce
  // on the last DF classifications, and derive press/repeat from code changes.
  int          hist[$];
  logic [15:0] m_code;
  int          since;
  logic        m_press;

  task automatic model_reset();
    hist.delete();
    m_code  = '0;
    since   = 0;
    m_press = 1'b0;
  endtask

  task automatic model_step(input logic [15:0] k);
    int          res;
    bit          same;
    logic [15:0] prev;
    prev = m_code;
    res  = 17;
    if ($countones(k) == 0) res = 16;
    else if ($countones(k) == 1)
      for (int i = 0; i < 16; i++) if (k[i]) res = i;
    hist.push_back(res);
    if (hist.size() > DF) void'(hist.pop_front());
    if (res != 17 && hist.size() == DF) begin
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != res) same = 1'b0;
      if (same) m_code = (res == 16) ? 16'h0 : (16'(1) << res);
    end
    m_press = 1'b0;
    if (m_code != prev) begin
      since   = 0;
      m_press = (prev == 16'h0);
    end else if (m_code != 16'h0) begin
      since++;
      if (REP && since >= RD && (since - RD) % RP == 0) m_press = 1'b1;
    end
  endtask

  // Starts at the negedge of a frame's first cycle, ends at the next frame's
  task automatic run_frame(input logic [15:0] k);
    keys = k;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) chk("press_idle", {31'd0, key_press}, 32'd0);
      @(negedge clk);
    end
    frame_no++;
    model_step(k);
  endtask

  task automatic chk_model();
    chk("onehot", {16'd0, onehot}, {16'd0, m_code});
    chk("key_valid", {31'd0, key_valid}, {31'd0, m_code != 16'h0});
    chk("key_press", {31'd0, key_press}, {31'd0, m_press});
  endtask

  typedef struct {
    logic [15:0] keys;
    logic [15:0] code;
    logic        press;
    logic        zero_match;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [15:0] k, input logic [15:0] c, input logic p, input logic z);
    vec_t v;
    v.keys = k; v.code = c; v.press = p; v.zero_match = z;
    tbl.push_back(v);
  endtask

  task automatic chk_rows(input int cycles);
    logic [3:0] one;
    one = 4'b0001;
    for (int n = 0; n < cycles; n++) begin
      chk("row_out", {28'd0, row_out}, {28'd0, ~(one << ((n / 4) % 4))});
      @(negedge clk);
    end
  endtask

  initial begin
    // press on row 1 / col 2, then release
    add(16'h0040, 16'h0000, 0, 0); add(16'h0040, 16'h0000, 0, 0);
    add(16'h0040, 16'h0040, 1, 0); add(16'h0040, 16'h0040, 0, 0);
    add(16'h0000, 16'h0040, 0, 0); add(16'h0000, 16'h0040, 0, 0);
    add(16'h0000, 16'h0000, 0, 0);
    // bounce
    for (int i = 0; i < 6; i++) add((i % 2 == 0) ? 16'h0040 : 16'h0000, 16'h0000, 0, 0);
    add(16'h0000, 16'h0000, 0, 0);
    // same-row multi, then cross-row ghost
    for (int i = 0; i < 5; i++) add(16'h0009, 16'h0000, 0, i == 4);
    for (int i = 0; i < 5; i++) add(16'h0201, 16'h0000, 0, i == 4);
    // key to key, then release
    add(16'h0020, 16'h0000, 0, 0); add(16'h0020, 16'h0000, 0, 0);
    add(16'h0020, 16'h0020, 1, 0);
    add(16'h0400, 16'h0020, 0, 0); add(16'h0400, 16'h0020, 0, 0);
    add(16'h0400, 16'h0400, 0, 0);
    add(16'h0000, 16'h0400, 0, 0); add(16'h0000, 16'h0400, 0, 0);
    add(16'h0000, 16'h0000, 0, 0);
    // long hold of idx 0 (repeats at held frames 7, 9, 11 and first release frame)
    add(16'h0001, 16'h0000, 0, 0); add(16'h0001, 16'h0000, 0, 0);
    add(16'h0001, 16'h0001, 1, 0);
    for (int f = 4; f <= 12; f++) add(16'h0001, 16'h0001, (f >= 7 && f % 2 == 1) ? REP : 1'b0, 0);
    add(16'h0000, 16'h0001, REP, 0); add(16'h0000, 16'h0001, 0, 0);
    add(16'h0000, 16'h0000, 0, 0);

    rst_n = 1'b0;
    keys  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_row_out", {28'd0, row_out}, 32'hE);
    chk("rst_onehot", {16'd0, onehot}, 32'h0);
    chk("rst_key_press", {31'd0, key_press}, 32'h0);
    chk("rst_key_valid", {31'd0, key_valid}, 32'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_frame(tbl[i].keys);
      chk("tbl_onehot", {16'd0, onehot}, {16'd0, tbl[i].code});
      chk("tbl_key_valid", {31'd0, key_valid}, {31'd0, tbl[i].code != 16'h0});
      chk("tbl_key_press", {31'd0, key_press}, {31'd0, tbl[i].press});
      if (tbl[i].zero_match) chk("tbl_match_cnt", 32'(dut.u_deb.match_cnt), 32'd0);
    end

    for (int f = 0; f < 40; f++) begin
      logic [15:0] k;
      int len;
      len = $urandom_range(1, 5);
      case ($urandom_range(0, 3))
        0:       k = 16'h0;
        3:       k = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        default: k = 16'(1) << $urandom_range(0, 15);
      endcase
      repeat (len) begin
        run_frame(k);
        chk_model();
      end
    end

    // debounced key, then reset in the middle of a row period
    repeat (3) begin
      run_frame(16'h0080);
      chk_model();
    end
    chk("pre_reset_onehot", {16'd0, onehot}, 32'h0080);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_row_out", {28'd0, row_out}, 32'hE);
    chk("mid_rst_onehot", {16'd0, onehot}, 32'h0);
    chk("mid_rst_key_press", {31'd0, key_press}, 32'h0);
    chk("mid_rst_key_valid", {31'd0, key_valid}, 32'h0);
    keys = '0;
    repeat (3) @(negedge clk);
    chk("held_rst_row_out", {28'd0, row_out}, 32'hE);
    rst_n = 1'b1;
    model_reset();
    chk_rows(32);

    // partial debounce state must not survive reset
    for (int i = 0; i < 3; i++) begin
      run_frame(16'h0080);
      chk_model();
      chk("post_rst_onehot", {16'd0, onehot}, (i == 2) ? 32'h0080 : 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
